mem_1r1w_sync_fifo_ctrl: RTL and testbench
==========================================

// Module: mem_1r1w_sync_fifo_ctrl
// PURPOSE
// - Single-clock FIFO control stage wrapped around mem_1r1w_sync_fpga for ethernet TX/RX buffering.
// - Upstream side: owns write/read pointers, issues mem write and read strobes, and gives a ready/valid input.
// - Downstream side: mirrors the memory's output pipeline occupancy, drives its valid_pipe/output_ready
//   inputs, and presents a ready/valid output.
// PARAMETERS
// - width_p            8   data width, passed straight to the memory
// - els_p              16  memory depth; power of 2, >=2
// - pipeline_output_p  2   memory output pipeline depth, >=1; same value as the memory instance
// PORTS
// - clk_i               in   1       single clock; connect to both w_clk_i and r_clk_i of the memory
// - reset_n_i           in   1       asynchronous, active-low reset
// - data_i              in   width_p upstream write data
// - v_i                 in   1       upstream valid
// - ready_o             out  1       upstream ready: FIFO memory not full
// - data_o              out  width_p downstream data (= mem_r_data_i)
// - v_o                 out  1       downstream valid: last pipe stage occupied
// - ready_i             in   1       downstream ready
// - mem_w_v_o/_addr_o/_data_o  out  1/clog2(els_p)/width_p  memory write port
// - mem_r_v_o/_addr_o   out  1/clog2(els_p)  memory read strobe/address
// - mem_r_data_i        in   width_p memory r_data_o
// - mem_output_ready_o  out  1       memory output_ready_i
// - mem_valid_pipe_o    out  pipeline_output_p  memory valid_pipe_reg_i (bit j = stage j holds data)
// - count_o             out  clog2(els_p+pipeline_output_p+1)  words in memory plus in pipe
// BEHAVIOUR
// - Reset (async assert, sync release): wptr=rptr=0, valid pipe=0; ready_o=1, v_o=0, mem_r_v_o=0,
//   mem_w_v_o=0, count_o=0. Reset mid-operation drops every stored and in-flight word; stale pipe_reg
//   contents in the memory are harmless because all valid bits clear.
// - Pointers carry one extra wrap bit. full = addr bits equal and wrap bits differ; empty = pointers equal.
// - Write: ready_o = ~full; mem_w_v_o = v_i & ready_o; addr = wptr[low]; wptr++ on write.
// - Stage advance (j>=1): adv[j] = ready_i | (~valid >> j) != 0, i.e. any bubble at stage j or later.
//   This must match the memory's shift rule exactly.
// - Stage 0 free: s0_free = ~valid[0] | adv[1]. For pipeline_output_p==1: s0_free = ~valid[0] | ready_i.
// - Read: mem_r_v_o = ~empty & s0_free; addr = rptr[low]; rptr++ on read.
//   The memory slot is released at read time, because the word is now held in pipe_reg.
// - Valid mirror, next state:
//   valid[0] = mem_r_v_o ? 1 : (s0_free ? 0 : valid[0]);
//   valid[j] = adv[j] ? valid[j-1] : valid[j].
// - mem_output_ready_o = ready_i; v_o = valid[N-1]; data_o = mem_r_data_i; a word leaves on v_o & ready_i.
// - mem_r_v_o is never asserted while stage 0 holds data that is not moving.
//   Reason: the memory overwrites pipe_reg[0] on every r_v.
// - Latency: write at edge t -> earliest read strobe in cycle t+1 -> v_o=1 after pipeline_output_p
//   more edges; with ready_i held high, throughput is 1 word/cycle.
// - Simultaneous write and read: legal in every state. Same-slot read/write cannot occur,
//   because a read requires ~empty and a write requires ~full.
// - Wrap: pointers roll over at 2*els_p; full/empty stay correct across the wrap.
// - count_o = (wptr-rptr) + popcount(valid), computed modulo wrap width. Registered inputs only, no comb
//   path from v_i or ready_i.
// - ready_o depends only on registers; ready_i reaches mem_r_v_o combinationally, through adv.
// STRUCTURE
// - No package needed; local addr_width_lp via BSG_SAFE_CLOG2.
// - One sub-module: mem_1r1w_sync_fifo_valid_pipe, which holds valid[], computes adv[] and s0_free,
//   and takes the read strobe.
// - Top level keeps pointers, full/empty, count.
// TESTING (els_p=4, pipeline_output_p=2, width_p=8)
// - Reset: after release, ready_o=1, v_o=0, count_o=0, mem_r_v_o=0.
// - Stream: write 0x11..0x14 in back-to-back cycles, ready_i=1 -> data_o 0x11..0x14 in order.
//   First v_o appears 3 cycles after the first write.
// - Full: ready_i=0, write 6 words -> ready_o drops after 6 writes (4 mem + 2 pipe) and count_o=6;
//   a 7th v_i is not accepted.
// - Bubble collapse: stall ready_i with only valid[1] set, then write one word -> word fills stage 0
//   while stage 1 holds; release -> both delivered in order.
// - Wrap: 20 words with random v_i/ready_i -> output sequence equals input sequence.
//   count_o matches the scoreboard on every cycle.
// - Mid-operation reset: assert reset_n_i low with count_o=5 -> v_o=0 and count_o=0 immediately.
//   After release, new data 0xA5 is delivered with no stale word.

Source files
------------

// File: rtl/mem_1r1w_sync_fifo_ctrl_pkg.sv
// Shared helpers for the 1R1W synchronous FIFO controller.
// Sizing functions used to derive pointer and count widths from the parameters.
package mem_1r1w_sync_fifo_ctrl_pkg;

   // Never returns zero, so a width derived from it is always a legal vector width.
   function automatic int safe_clog2(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

   // Pointer carries one wrap bit above the slot address.
   function automatic int ptr_width(input int els);
      return safe_clog2(els) + 1;
   endfunction

endpackage

// File: rtl/mem_1r1w_sync_fifo_valid_pipe.sv
// Occupancy mirror of the memory's output pipeline: holds one valid bit per stage,
// derives the per-stage advance enables and whether stage 0 can take a new read.
module mem_1r1w_sync_fifo_valid_pipe #(
   parameter int pipeline_output_p = 2
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         ready_i,
   input  logic                         r_v_i,
   output logic [pipeline_output_p-1:0] valid_o,
   output logic                         s0_free_o
);

   logic [pipeline_output_p-1:0] r_valid;
   logic [pipeline_output_p-1:0] w_valid_nxt;
   logic [pipeline_output_p-1:0] w_hole;
   logic [pipeline_output_p-1:0] w_adv;

   // w_hole[j]: some stage at j or beyond is empty, so everything from j onward can shift.
   always_comb begin : hole_scan
      logic v_hole;
      // NOTE: every combinational output gets a default before any conditional logic, so no latch is inferred.
      w_hole = '0;
      v_hole = 1'b0;
      for (int j = 0; j < pipeline_output_p; j++) begin
         v_hole = 1'b0;
         for (int k = j; k < pipeline_output_p; k++) begin
            v_hole = v_hole | ~r_valid[k];
         end
         w_hole[j] = v_hole;
      end
   end

   // Bit 0 of the advance vector doubles as "stage 0 free": ~valid[0] | adv[1] folds into it.
   assign w_adv     = {pipeline_output_p{ready_i}} | w_hole;
   assign s0_free_o = w_adv[0];

   always_comb begin
      w_valid_nxt = r_valid;
      if (r_v_i) begin
         w_valid_nxt[0] = 1'b1;
      end else if (w_adv[0]) begin
         w_valid_nxt[0] = 1'b0;
      end
      for (int j = 1; j < pipeline_output_p; j++) begin
         if (w_adv[j]) begin
            w_valid_nxt[j] = r_valid[j-1];
         end
      end
   end

   // NOTE: sequential state is written only with non-blocking assignments; async reset clears the valid bits.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_valid <= '0;
      end else begin
         r_valid <= w_valid_nxt;
      end
   end

   assign valid_o = r_valid;

endmodule

// File: rtl/mem_1r1w_sync_fifo_ctrl.sv
// Single-clock FIFO control around a 1R1W synchronous memory with an output pipeline.
// Owns the write/read pointers and occupancy count; the valid mirror lives in the sub-module.
module mem_1r1w_sync_fifo_ctrl
   import mem_1r1w_sync_fifo_ctrl_pkg::*;
#(
   parameter int width_p           = 8,
   parameter int els_p             = 16,
   parameter int pipeline_output_p = 2,
   localparam int addr_width_lp    = safe_clog2(els_p),
   localparam int count_width_lp   = safe_clog2(els_p + pipeline_output_p + 1)
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,

   input  logic [width_p-1:0]           data_i,
   input  logic                         v_i,
   output logic                         ready_o,

   output logic [width_p-1:0]           data_o,
   output logic                         v_o,
   input  logic                         ready_i,

   output logic                         mem_w_v_o,
   output logic [addr_width_lp-1:0]     mem_w_addr_o,
   output logic [width_p-1:0]           mem_w_data_o,
   output logic                         mem_r_v_o,
   output logic [addr_width_lp-1:0]     mem_r_addr_o,
   input  logic [width_p-1:0]           mem_r_data_i,
   output logic                         mem_output_ready_o,
   output logic [pipeline_output_p-1:0] mem_valid_pipe_o,

   output logic [count_width_lp-1:0]    count_o
);

   localparam int ptr_width_lp = ptr_width(els_p);

   logic [ptr_width_lp-1:0]      r_wptr;
   logic [ptr_width_lp-1:0]      r_rptr;
   logic [ptr_width_lp-1:0]      w_used;
   logic                         w_full;
   logic                         w_empty;
   logic                         w_write;
   logic                         w_read;
   logic                         w_s0_free;
   logic [pipeline_output_p-1:0] w_valid;
   logic [count_width_lp-1:0]    w_in_pipe;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[addr_width_lp] != r_rptr[addr_width_lp]) &&
                    (r_wptr[addr_width_lp-1:0] == r_rptr[addr_width_lp-1:0]);

   assign w_write = v_i & ~w_full;
   // A memory slot is released at read time: the word now lives in pipe stage 0.
   assign w_read  = ~w_empty & w_s0_free;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_write) begin
            r_wptr <= r_wptr + ptr_width_lp'(1);
         end
         if (w_read) begin
            r_rptr <= r_rptr + ptr_width_lp'(1);
         end
      end
   end

   mem_1r1w_sync_fifo_valid_pipe #(
      .pipeline_output_p(pipeline_output_p)
   ) u_valid_pipe (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .ready_i  (ready_i),
      .r_v_i    (w_read),
      .valid_o  (w_valid),
      .s0_free_o(w_s0_free)
   );

   // Occupancy from registers only: words parked in memory plus words in flight in the pipe.
   assign w_used = r_wptr - r_rptr;

   always_comb begin
      w_in_pipe = '0;
      for (int j = 0; j < pipeline_output_p; j++) begin
         w_in_pipe = w_in_pipe + count_width_lp'(w_valid[j]);
      end
   end

   assign count_o            = count_width_lp'(w_used) + w_in_pipe;

   assign ready_o            = ~w_full;
   assign mem_w_v_o          = w_write;
   assign mem_w_addr_o       = r_wptr[addr_width_lp-1:0];
   assign mem_w_data_o       = data_i;

   assign mem_r_v_o          = w_read;
   assign mem_r_addr_o       = r_rptr[addr_width_lp-1:0];
   assign mem_output_ready_o = ready_i;
   assign mem_valid_pipe_o   = w_valid;

   assign v_o                = w_valid[pipeline_output_p-1];
   assign data_o             = mem_r_data_i;

endmodule

// File: tb/tb_mem_1r1w_sync_fifo_ctrl.sv
// Self-checking bench: behavioural memory with output pipeline, queue scoreboard,
// directed latency/full/bubble/reset scenarios and a randomized wrap run.
module tb_mem_1r1w_sync_fifo_ctrl;

   localparam int W  = 8;
   localparam int E  = 4;
   localparam int P  = 2;
   localparam int AW = 2;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset_n_i;
   logic [W-1:0]  data_i;
   logic          v_i;
   logic          ready_o;
   logic [W-1:0]  data_o;
   logic          v_o;
   logic          ready_i;
   logic          mem_w_v_o;
   logic [AW-1:0] mem_w_addr_o;
   logic [W-1:0]  mem_w_data_o;
   logic          mem_r_v_o;
   logic [AW-1:0] mem_r_addr_o;
   logic [W-1:0]  mem_r_data_i;
   logic          mem_output_ready_o;
   logic [P-1:0]  mem_valid_pipe_o;
   logic [CW-1:0] count_o;

   always #5 clk = ~clk;

   mem_1r1w_sync_fifo_ctrl #(
      .width_p          (W),
      .els_p            (E),
      .pipeline_output_p(P)
   ) dut (
      .clk_i             (clk),
      .reset_n_i         (reset_n_i),
      .data_i            (data_i),
      .v_i               (v_i),
      .ready_o           (ready_o),
      .data_o            (data_o),
      .v_o               (v_o),
      .ready_i           (ready_i),
      .mem_w_v_o         (mem_w_v_o),
      .mem_w_addr_o      (mem_w_addr_o),
      .mem_w_data_o      (mem_w_data_o),
      .mem_r_v_o         (mem_r_v_o),
      .mem_r_addr_o      (mem_r_addr_o),
      .mem_r_data_i      (mem_r_data_i),
      .mem_output_ready_o(mem_output_ready_o),
      .mem_valid_pipe_o  (mem_valid_pipe_o),
      .count_o           (count_o)
   );

   // Behavioural memory: array, plus an output pipe whose data registers are never reset.
   logic [W-1:0] m_mem  [E];
   logic [W-1:0] m_pipe [P];

   function automatic bit stage_moves(input int j);
      if (mem_output_ready_o) return 1'b1;
      for (int k = j; k < P; k++) begin
         if (!mem_valid_pipe_o[k]) return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      if (mem_w_v_o) m_mem[mem_w_addr_o] <= mem_w_data_o;
      if (mem_r_v_o) m_pipe[0] <= m_mem[mem_r_addr_o];
      for (int j = 1; j < P; j++) begin
         if (stage_moves(j)) m_pipe[j] <= m_pipe[j-1];
      end
   end

   assign mem_r_data_i = m_pipe[P-1];

   // Scoreboard: every accepted word queued, every delivered word must match the head.
   logic [W-1:0] sb_q [$];
   int           n_acc = 0;
   int           n_del = 0;
   logic [W-1:0] last_del;
   int           n_checks = 0;
   int           n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   always @(negedge clk) begin
      if (reset_n_i) begin
         check("count", 32'(count_o), 32'(sb_q.size()));
         if (v_o && ready_i) begin
            if (sb_q.size() == 0) check("underflow", 32'd1, 32'd0);
            else check("data", 32'(data_o), 32'(sb_q.pop_front()));
            last_del = data_o;
            n_del++;
         end
         if (v_i && ready_o) begin
            sb_q.push_back(data_i);
            n_acc++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int budget);
      int i = 0;
      while (sb_q.size() != 0 && i < budget) begin
         tick();
         i++;
      end
      check("drain_left", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int a0;
      reset_n_i = 1'b0;
      v_i       = 1'b0;
      ready_i   = 1'b0;
      data_i    = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_v_o", 32'(v_o), 32'd0);
      reset_n_i = 1'b1;
      #1;
      check("rel_ready", 32'(ready_o), 32'd1);
      check("rel_v_o", 32'(v_o), 32'd0);
      check("rel_count", 32'(count_o), 32'd0);
      check("rel_r_v", 32'(mem_r_v_o), 32'd0);
      tick();

      // Stream with latency: first v_o three cycles after first write
      ready_i = 1'b1;
      d0 = n_del;
      for (int i = 0; i < 4; i++) begin
         v_i    = 1'b1;
         data_i = 8'h11 + 8'(i);
         if (i == 2) check("lat_early", 32'(v_o), 32'd0);
         if (i == 3) begin
            check("lat_v_o", 32'(v_o), 32'd1);
            check("lat_data", 32'(data_o), 32'h11);
         end
         tick();
      end
      v_i = 1'b0;
      wait_drain(50);
      check("stream_n", 32'(n_del - d0), 32'd4);

      // Full: 4 in memory plus 2 in the pipe
      ready_i = 1'b0;
      d0 = n_del;
      for (int i = 0; i < 6; i++) begin
         check("full_rdy", 32'(ready_o), 32'd1);
         v_i    = 1'b1;
         data_i = 8'h21 + 8'(i);
         tick();
      end
      check("full_drop", 32'(ready_o), 32'd0);
      check("full_count", 32'(count_o), 32'd6);
      data_i = 8'hEE;
      tick();
      v_i = 1'b0;
      check("full_7th", 32'(count_o), 32'd6);
      ready_i = 1'b1;
      wait_drain(50);
      check("full_n", 32'(n_del - d0), 32'd6);

      // Bubble collapse: stage 1 held, a new word fills stage 0 behind it
      ready_i = 1'b0;
      d0 = n_del;
      v_i = 1'b1;
      data_i = 8'h31;
      tick();
      v_i = 1'b0;
      repeat (3) tick();
      check("bub_pipe10", 32'(mem_valid_pipe_o), 32'b10);
      v_i = 1'b1;
      data_i = 8'h32;
      tick();
      v_i = 1'b0;
      tick();
      check("bub_pipe11", 32'(mem_valid_pipe_o), 32'b11);
      check("bub_head", 32'(data_o), 32'h31);
      ready_i = 1'b1;
      wait_drain(50);
      check("bub_n", 32'(n_del - d0), 32'd2);

      // Random wrap: 20 words, random valid and ready
      d0 = n_del;
      a0 = n_acc;
      for (int c = 0; c < 2000 && (n_acc - a0) < 20; c++) begin
         v_i     = 1'($urandom_range(0, 1));
         ready_i = 1'($urandom_range(0, 1));
         data_i  = 8'($urandom);
         tick();
      end
      v_i = 1'b0;
      check("rnd_acc", 32'(n_acc - a0), 32'd20);
      ready_i = 1'b1;
      wait_drain(100);
      check("rnd_n", 32'(n_del - d0), 32'd20);

      // Mid-operation reset with five words stored
      ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         v_i    = 1'b1;
         data_i = 8'h51 + 8'(i);
         tick();
      end
      v_i = 1'b0;
      check("mid_count", 32'(count_o), 32'd5);
      reset_n_i = 1'b0;
      sb_q.delete();
      #1;
      check("mid_v_o", 32'(v_o), 32'd0);
      check("mid_count0", 32'(count_o), 32'd0);
      tick();
      tick();
      reset_n_i = 1'b1;
      d0 = n_del;
      ready_i = 1'b1;
      v_i = 1'b1;
      data_i = 8'hA5;
      tick();
      v_i = 1'b0;
      wait_drain(50);
      repeat (3) tick();
      check("post_n", 32'(n_del - d0), 32'd1);
      check("post_word", 32'(last_del), 32'hA5);
      check("post_count", 32'(count_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
